// File: rtl/jt12_wrseq.sv
// jt12_wrseq: queued register-write bus initiator for the jt12 FM core
module jt12_wrseq #(
    parameter int FIFO_AW  = 3,
    parameter int STROBE   = 2,
    parameter int BUSY_TMO = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_bank,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_val,
    input  logic [7:0] ym_din,
    output logic [1:0] ym_addr,
    output logic [7:0] ym_dout,
    output logic       ym_cs_n,
    output logic       ym_wr_n,
    output logic       idle,
    output logic       timeout_err,
    input  logic       err_clr
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BW = $clog2(BUSY_TMO + 1);
    localparam int SW = $clog2(STROBE + 1);
    typedef enum logic [2:0] {IDLE, POLL, AWR, AGAP, DWR, DGAP} state_t;
    state_t state, state_nx;
    logic [16:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wp, rp;
    logic [FIFO_AW:0] cnt;
    logic [16:0] hold, hold_nx;
    logic [BW-1:0] bcnt, bcnt_nx;
    logic [SW-1:0] scnt, scnt_nx;
    logic empty, push, pop, tmo_set, strobe_nx, din_unused;
    logic [1:0] addr_nx;
    logic [7:0] dout_nx;
    assign empty = cnt == '0;
    assign cmd_ready = cnt != (FIFO_AW+1)'(DEPTH);
    assign push = cmd_valid && cmd_ready;
    assign pop = cen && state == IDLE && !empty;
    assign idle = empty && state == IDLE;
    assign din_unused = ^ym_din[6:0];
    // command storage, written on any clk regardless of cen
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {cmd_bank, cmd_reg, cmd_val};
    end
    // FIFO pointers and occupancy; simultaneous push and pop leave cnt alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + FIFO_AW'(1);
            if (pop) rp <= rp + FIFO_AW'(1);
            if (push != pop) cnt <= push ? cnt + (FIFO_AW+1)'(1) : cnt - (FIFO_AW+1)'(1);
        end
    end
    // sequencer next state: busy poll, address strobe, gap, data strobe, gap
    always_comb begin
        state_nx = state;
        hold_nx  = hold;
        bcnt_nx  = bcnt;
        scnt_nx  = scnt;
        tmo_set  = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                hold_nx  = mem[rp];
                bcnt_nx  = '0;
                state_nx = POLL;
            end
            POLL: if (!ym_din[7]) begin
                scnt_nx  = '0;
                state_nx = AWR;
            end else if (bcnt == BW'(BUSY_TMO - 1)) begin
                tmo_set  = 1'b1;
                scnt_nx  = '0;
                state_nx = AWR;
            end else begin
                bcnt_nx = bcnt + BW'(1);
            end
            AWR: if (scnt == SW'(STROBE - 1)) state_nx = AGAP;
                 else scnt_nx = scnt + SW'(1);
            AGAP: begin
                scnt_nx  = '0;
                state_nx = DWR;
            end
            DWR: if (scnt == SW'(STROBE - 1)) state_nx = DGAP;
                 else scnt_nx = scnt + SW'(1);
            DGAP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // pin values are derived from the next state so registered pins line up with the state register
    always_comb begin
        strobe_nx = !(state_nx == AWR || state_nx == DWR);
        addr_nx = (state_nx == DWR || state_nx == DGAP) ? {hold_nx[16], 1'b1} :
                  (state_nx == IDLE) ? ym_addr : {hold_nx[16], 1'b0};
        dout_nx = (state_nx == DWR || state_nx == DGAP) ? hold_nx[7:0] :
                  (state_nx == IDLE) ? ym_dout : hold_nx[15:8];
    end
    // sequencer state and holding register, advancing on cen only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hold  <= '0;
            bcnt  <= '0;
            scnt  <= '0;
        end else if (cen) begin
            state <= state_nx;
            hold  <= hold_nx;
            bcnt  <= bcnt_nx;
            scnt  <= scnt_nx;
        end
    end
    // registered chip pins; reset forces strobes inactive immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ym_cs_n <= 1'b1;
            ym_wr_n <= 1'b1;
            ym_addr <= '0;
            ym_dout <= '0;
        end else if (cen) begin
            ym_cs_n <= strobe_nx;
            ym_wr_n <= strobe_nx;
            ym_addr <= addr_nx;
            ym_dout <= dout_nx;
        end
    end
    // sticky busy-timeout flag; a new timeout beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timeout_err <= 1'b0;
        else if (cen && tmo_set) timeout_err <= 1'b1;
        else if (err_clr) timeout_err <= 1'b0;
    end
endmodule

// File: tb/tb_jt12_wrseq.sv
// tb_jt12_wrseq: directed self-checking bench for jt12_wrseq
module tb_jt12_wrseq;
    logic       clk = 1'b0;
    logic       rst_n, cen, cmd_valid, cmd_ready, cmd_bank, err_clr;
    logic [7:0] cmd_reg, cmd_val, ym_din, ym_dout;
    logic [1:0] ym_addr;
    logic       ym_cs_n, ym_wr_n, idle, timeout_err;
    int         checks = 0;
    int         errors = 0;
    logic       seen;

    jt12_wrseq dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_bank(cmd_bank),
        .cmd_reg(cmd_reg), .cmd_val(cmd_val), .ym_din(ym_din),
        .ym_addr(ym_addr), .ym_dout(ym_dout), .ym_cs_n(ym_cs_n), .ym_wr_n(ym_wr_n),
        .idle(idle), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic clk1();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {cs_n, wr_n, addr, dout, idle} after the k-th cen of a command (k=0 is the pop)
    function automatic logic [12:0] exp_at(input logic b, input logic [7:0] r, input logic [7:0] v,
                                           input int k, input bit li);
        logic s;
        s = !(k == 1 || k == 2 || k == 4 || k == 5);
        return {s, s, b, (k >= 4), (k >= 4) ? v : r, li && k == 7};
    endfunction

    task automatic check_seq(input logic b, input logic [7:0] r, input logic [7:0] v,
                             input bit half, input bit last_idle, input int first_k, input string tag);
        for (int k = first_k; k < 8; k++) begin
            logic [12:0] e, p;
            if (half) begin
                p = (k == 0) ? 13'h1800 : exp_at(b, r, v, k - 1, last_idle);
                cen = 1'b0;
                clk1();
                chk($sformatf("%s_hold_k%0d", tag, k), {30'd0, ym_cs_n, ym_wr_n}, {30'd0, p[12:11]});
                cen = 1'b1;
            end
            e = exp_at(b, r, v, k, last_idle);
            clk1();
            chk($sformatf("%s_k%0d", tag, k), {19'd0, ym_cs_n, ym_wr_n, ym_addr, ym_dout, idle}, {19'd0, e});
        end
    endtask

    initial begin
        rst_n = 1'b0; cen = 1'b1; cmd_valid = 1'b0; cmd_bank = 1'b0;
        cmd_reg = '0; cmd_val = '0; ym_din = '0; err_clr = 1'b0;
        repeat (2) clk1();
        chk("reset", {ym_cs_n, ym_wr_n, ym_addr, ym_dout, cmd_ready, idle, timeout_err}, {2'b11, 2'b00, 8'h00, 3'b110});
        rst_n = 1'b1;
        clk1();
        chk("reset_idle", {idle, cmd_ready, ym_wr_n}, 3'b111);

        // single write at bank 0
        cmd_valid = 1'b1; cmd_bank = 1'b0; cmd_reg = 8'h28; cmd_val = 8'hF0;
        clk1();
        cmd_valid = 1'b0;
        chk("s1_push_idle", idle, 1'b0);
        check_seq(1'b0, 8'h28, 8'hF0, 1'b0, 1'b1, 0, "s1");

        // bank 1 with busy for 10 polls
        ym_din = 8'h80;
        cmd_valid = 1'b1; cmd_bank = 1'b1; cmd_reg = 8'hA4; cmd_val = 8'h22;
        clk1();
        cmd_valid = 1'b0;
        clk1();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("s2_poll%0d", i), {ym_cs_n, ym_wr_n, ym_addr}, 4'b1110);
            clk1();
        end
        ym_din = 8'h00;
        clk1();
        chk("s2_awr", {ym_cs_n, ym_wr_n, ym_addr, ym_dout}, {4'b0010, 8'hA4});
        check_seq(1'b1, 8'hA4, 8'h22, 1'b0, 1'b1, 2, "s2");
        chk("s2_no_tmo", timeout_err, 1'b0);

        // busy stuck: forced write after 255 polls, clear on the forcing edge loses
        ym_din = 8'h80;
        cmd_valid = 1'b1; cmd_bank = 1'b0; cmd_reg = 8'h30; cmd_val = 8'h71;
        clk1();
        cmd_valid = 1'b0;
        clk1();
        repeat (254) clk1();
        chk("s3_polling", {ym_cs_n, ym_wr_n, timeout_err}, 3'b110);
        err_clr = 1'b1;
        clk1();
        err_clr = 1'b0;
        chk("s3_forced", {ym_cs_n, ym_wr_n, ym_addr, ym_dout, timeout_err}, {4'b0000, 8'h30, 1'b1});
        check_seq(1'b0, 8'h30, 8'h71, 1'b0, 1'b1, 2, "s3");
        chk("s3_sticky", timeout_err, 1'b1);
        err_clr = 1'b1;
        clk1();
        err_clr = 1'b0;
        chk("s3_clr", timeout_err, 1'b0);
        ym_din = 8'h00;

        // fill FIFO with cen low, ninth push ignored, then drain in order
        cen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cmd_valid = 1'b1; cmd_bank = i[0]; cmd_reg = 8'h40 + 8'(i); cmd_val = 8'hA0 + 8'(i);
            chk($sformatf("s4_ready%0d", i), cmd_ready, (i < 8) ? 1'b1 : 1'b0);
            clk1();
        end
        cmd_valid = 1'b0;
        chk("s4_full", {cmd_ready, idle, ym_wr_n}, 3'b001);
        cen = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] iv;
            iv = 32'(i);
            check_seq(iv[0], 8'h40 + 8'(i), 8'hA0 + 8'(i), 1'b0, i == 7, 0, $sformatf("s4_c%0d", i));
        end

        // reset during the data strobe discards everything
        cmd_valid = 1'b1; cmd_bank = 1'b1; cmd_reg = 8'h55; cmd_val = 8'h66;
        clk1();
        cmd_reg = 8'h77; cmd_val = 8'h88;
        clk1();
        cmd_valid = 1'b0;
        repeat (4) clk1();
        chk("s5_dwr", {ym_cs_n, ym_wr_n, ym_addr, ym_dout}, {4'b0011, 8'h66});
        #2 rst_n = 1'b0;
        #1 chk("s5_async", {ym_cs_n, ym_wr_n, idle, cmd_ready}, 4'b1111);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            clk1();
            seen = seen | !ym_cs_n | !ym_wr_n | !idle;
        end
        chk("s5_quiet", {seen, ym_addr, ym_dout}, 11'd0);

        // cen every other clk
        cen = 1'b0;
        cmd_valid = 1'b1; cmd_bank = 1'b0; cmd_reg = 8'h28; cmd_val = 8'hF0;
        clk1();
        cmd_valid = 1'b0;
        check_seq(1'b0, 8'h28, 8'hF0, 1'b1, 1'b1, 0, "s6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
